// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Request, data-bus and register-file writeback signals of the load/store unit.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        RUWr;
    logic [4:0]  rd;
    logic [31:0] datawr;
    logic        done;
    logic        err;

    // The unit itself
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output RUWr, rd, datawr, done, err
    );

    // The surrounding core and memory
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  RUWr, rd, datawr, done, err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extraction/extension,
// and the alignment/funct3 legality check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_ldata,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // funct3[1:0] encodes access size for both loads and stores
    always_comb begin
        if (i_we) begin
            o_illegal = (i_funct3 > F3_W);
        end else begin
            o_illegal = (i_funct3 == 3'd3) || (i_funct3 > F3_HU);
        end
        if ((i_funct3[1:0] == 2'd1) && i_addrLo[0]) begin
            o_illegal = 1'b1;
        end
        if ((i_funct3[1:0] == 2'd2) && (i_addrLo != 2'd0)) begin
            o_illegal = 1'b1;
        end
    end

    always_comb begin
        o_wdata = i_wdata;
        o_wstrb = 4'b0000;
        if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_wdata = {4{i_wdata[7:0]}};
                    o_wstrb = 4'b0001 << i_addrLo;
                end
                F3_H: begin
                    o_wdata = {2{i_wdata[15:0]}};
                    o_wstrb = 4'b0011 << i_addrLo;
                end
                F3_W:    o_wstrb = 4'b1111;
                default: o_wstrb = 4'b0000;
            endcase
        end
    end

    always_comb begin
        case (i_addrLo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
            F3_W:    o_ldata = i_rdata;
            F3_BU:   o_ldata = {24'd0, w_byte};
            F3_HU:   o_ldata = {16'd0, w_half};
            default: o_ldata = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store engine: request latch, bus handshake FSM and
// one-cycle register-file writeback on load completion.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);

    lsu_state_t  r_state;
    lsu_state_t  w_nextState;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic        r_err;
    logic [31:0] r_datawr;
    logic [31:0] r_memWdata;
    logic [3:0]  r_memWstrb;

    logic        w_idle;
    logic        w_accept;
    logic        w_alignWe;
    logic [2:0]  w_alignFunct3;
    logic [1:0]  w_alignAddrLo;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_ldata;
    logic        w_illegal;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && bus.req_valid;

    // The aligner sees the incoming request while idle and the latched one afterwards
    assign w_alignWe     = w_idle ? bus.req_we         : r_we;
    assign w_alignFunct3 = w_idle ? bus.req_funct3     : r_funct3;
    assign w_alignAddrLo = w_idle ? bus.req_addr[1:0]  : r_addr[1:0];

    lsu_align u_align (
        .i_we      (w_alignWe),
        .i_funct3  (w_alignFunct3),
        .i_addrLo  (w_alignAddrLo),
        .i_wdata   (bus.req_wdata),
        .i_rdata   (bus.mem_rdata),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb),
        .o_ldata   (w_ldata),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_nextState = w_illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    w_nextState = r_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (bus.mem_rvalid) begin
                    w_nextState = S_DONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_rd       <= 5'd0;
            r_err      <= 1'b0;
            r_datawr   <= 32'd0;
            r_memWdata <= 32'd0;
            r_memWstrb <= 4'd0;
        end else if (w_accept) begin
            r_we       <= bus.req_we;
            r_funct3   <= bus.req_funct3;
            r_addr     <= bus.req_addr;
            r_rd       <= bus.req_rd;
            r_err      <= w_illegal;
            r_datawr   <= 32'd0;
            r_memWdata <= w_wdata;
            r_memWstrb <= w_illegal ? 4'd0 : w_wstrb;
        end else if ((r_state == S_RESP) && bus.mem_rvalid) begin
            r_datawr <= w_ldata;
        end
    end

    assign bus.req_ready = w_idle;
    assign bus.mem_valid = (r_state == S_REQ);
    assign bus.mem_we    = (r_state == S_REQ) && r_we;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = r_memWdata;
    assign bus.mem_wstrb = r_memWstrb;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_DONE) && r_err;
    // rd=0 is the hardwired zero register, so it never gets a write pulse
    assign bus.RUWr      = (r_state == S_DONE) && !r_err && !r_we && (r_rd != 5'd0);
    assign bus.rd        = r_rd;
    assign bus.datawr    = r_datawr;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven scoreboard bench for load_store_unit plus hand-written reset sequences.
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          reqWaits;
        int          respWaits;
        logic        expErr;
        logic [31:0] expMemAddr;
        logic [31:0] expMemWdata;
        logic [3:0]  expWstrb;
        logic        expRUWr;
        logic [31:0] expDatawr;
        int          expLat;
    } vec_t;

    logic clk;
    logic reset;
    lsu_if bus();

    vec_t vecs[$];
    vec_t sbQ[$];
    int   checkCount;
    int   passCount;

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                                   input int reqWaits, input int respWaits, input logic expErr,
                                   input logic [31:0] expMemAddr, input logic [31:0] expMemWdata,
                                   input logic [3:0] expWstrb, input logic expRUWr,
                                   input logic [31:0] expDatawr, input int expLat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
        v.reqWaits = reqWaits; v.respWaits = respWaits; v.expErr = expErr;
        v.expMemAddr = expMemAddr; v.expMemWdata = expMemWdata; v.expWstrb = expWstrb;
        v.expRUWr = expRUWr; v.expDatawr = expDatawr; v.expLat = expLat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic clearInputs();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 5'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
    endtask

    // Drives one request at a negedge, plays the memory side, and scores the completion
    task automatic applyStimulus(input vec_t v);
        vec_t e;
        bit   seenBus;
        bit   hs;
        bit   inResp;
        bit   finished;
        int   reqW;
        int   respW;
        int   cyc;
        seenBus = 0; inResp = 0; finished = 0; reqW = 0; respW = 0;
        checkOutput("idleReady", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("idleDone", {31'd0, bus.done}, 32'd0);
        driveReq(v.we, v.f3, v.addr, v.wdata, v.rd);
        sbQ.push_back(v);
        @(negedge clk);
        cyc = 1;
        bus.req_valid = 1'b0;
        while (!finished && cyc <= 40) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            hs = 0;
            if (bus.done) begin
                e = sbQ.pop_front();
                checkOutput("latency", cyc, e.expLat);
                checkOutput("err", {31'd0, bus.err}, {31'd0, e.expErr});
                checkOutput("RUWr", {31'd0, bus.RUWr}, {31'd0, e.expRUWr});
                if (e.expRUWr) begin
                    checkOutput("rd", {27'd0, bus.rd}, {27'd0, e.rd});
                    checkOutput("datawr", bus.datawr, e.expDatawr);
                end
                finished = 1;
            end else begin
                checkOutput("RUWrOutsideDone", {31'd0, bus.RUWr}, 32'd0);
                if (bus.mem_valid) begin
                    if (sbQ[0].expErr) begin
                        checkOutput("noBusOnErr", {31'd0, bus.mem_valid}, 32'd0);
                    end
                    if (!seenBus) begin
                        seenBus = 1;
                        checkOutput("busLatency", cyc, 1);
                        checkOutput("memWe", {31'd0, bus.mem_we}, {31'd0, sbQ[0].we});
                        if (sbQ[0].we) begin
                            checkOutput("memWdata", bus.mem_wdata, sbQ[0].expMemWdata);
                        end
                    end
                    checkOutput("memAddr", bus.mem_addr, sbQ[0].expMemAddr);
                    checkOutput("memWstrb", {28'd0, bus.mem_wstrb}, {28'd0, sbQ[0].expWstrb});
                    if (reqW == v.reqWaits) begin
                        bus.mem_ready = 1'b1;
                        hs = 1;
                    end
                    reqW++;
                end else if (inResp) begin
                    if (respW == v.respWaits) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = v.rdata;
                        inResp = 0;
                    end
                    respW++;
                end
                @(negedge clk);
                cyc++;
                if (hs && !v.we) inResp = 1;
            end
        end
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!finished) begin
            checkOutput("doneTimeout", 32'd0, 32'd1);
            if (sbQ.size() != 0) e = sbQ.pop_front();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_memValid"}, {31'd0, bus.mem_valid}, 32'd0);
        checkOutput({tag, "_memWe"}, {31'd0, bus.mem_we}, 32'd0);
        checkOutput({tag, "_memWstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
        checkOutput({tag, "_memAddr"}, bus.mem_addr, 32'd0);
        checkOutput({tag, "_memWdata"}, bus.mem_wdata, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        checkOutput({tag, "_RUWr"}, {31'd0, bus.RUWr}, 32'd0);
        checkOutput({tag, "_rd"}, {27'd0, bus.rd}, 32'd0);
        checkOutput({tag, "_datawr"}, bus.datawr, 32'd0);
        checkOutput({tag, "_reqReady"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset = 1'b0;
        clearInputs();

        //            we    f3    addr          wdata         rd     rdata         rqW rsW err memAddr       memWdata      strb     RUWr datawr        lat
        vecs.push_back(mkVec(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd0,  32'h0,        0, 0, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b0, 32'h0,        2));
        vecs.push_back(mkVec(1'b0, 3'd0, 32'h0000_2001, 32'h0,        5'd5,  32'h0000_8000, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'hFFFF_FF80, 3));
        vecs.push_back(mkVec(1'b0, 3'd4, 32'h0000_2001, 32'h0,        5'd5,  32'h0000_8000, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'h0000_0080, 3));
        vecs.push_back(mkVec(1'b0, 3'd1, 32'h0000_2002, 32'h0,        5'd7,  32'h8001_0000, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'hFFFF_8001, 3));
        vecs.push_back(mkVec(1'b0, 3'd1, 32'h0000_2003, 32'h0,        5'd7,  32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1));
        vecs.push_back(mkVec(1'b0, 3'd2, 32'h0000_3000, 32'h0,        5'd0,  32'hDEAD_BEEF, 2, 2, 1'b0, 32'h0000_3000, 32'h0,        4'b0000, 1'b0, 32'h0,        7));
        vecs.push_back(mkVec(1'b0, 3'd3, 32'h0000_4000, 32'h0,        5'd3,  32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1));
        vecs.push_back(mkVec(1'b1, 3'd4, 32'h0000_4000, 32'h1111_2222, 5'd0,  32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1));
        vecs.push_back(mkVec(1'b1, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 5'd0,  32'h0,        0, 0, 1'b0, 32'h0000_1000, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'h0,        2));
        vecs.push_back(mkVec(1'b1, 3'd2, 32'h0000_1004, 32'hCAFE_F00D, 5'd0,  32'h0,        1, 0, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,        3));
        vecs.push_back(mkVec(1'b0, 3'd5, 32'h0000_2000, 32'h0,        5'd31, 32'h1234_F00D, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'h0000_F00D, 3));
        vecs.push_back(mkVec(1'b0, 3'd2, 32'h0000_2008, 32'h0,        5'd1,  32'h89AB_CDEF, 0, 1, 1'b0, 32'h0000_2008, 32'h0,        4'b0000, 1'b1, 32'h89AB_CDEF, 4));
        vecs.push_back(mkVec(1'b1, 3'd2, 32'h0000_1002, 32'h5555_AAAA, 5'd0,  32'h0,        0, 0, 1'b1, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1));
        vecs.push_back(mkVec(1'b0, 3'd0, 32'h0000_2000, 32'h0,        5'd2,  32'h0000_007F, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'h0000_007F, 3));
        vecs.push_back(mkVec(1'b0, 3'd0, 32'h0000_2003, 32'h0,        5'd2,  32'h8000_0000, 0, 0, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 1'b1, 32'hFFFF_FF80, 3));
        vecs.push_back(mkVec(1'b1, 3'd0, 32'h0000_1001, 32'h0000_0037, 5'd0,  32'h0,        0, 0, 1'b0, 32'h0000_1000, 32'h3737_3737, 4'b0010, 1'b0, 32'h0,        2));

        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("por");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset while the bus request is stalled
        driveReq(1'b0, 3'd2, 32'h0000_5004, 32'h0, 5'd9);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("rstReq_preValid", {31'd0, bus.mem_valid}, 32'd1);
        reset = 1'b0;
        #1;
        checkResetOutputs("rstReq");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset while waiting for read data, then a stale rvalid arrives
        driveReq(1'b0, 3'd2, 32'h0000_5008, 32'h0, 5'd9);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        checkOutput("rstResp_preValid", {31'd0, bus.mem_valid}, 32'd0);
        checkOutput("rstResp_preReady", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        checkResetOutputs("rstResp");
        @(negedge clk);
        reset = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("lateRvalid_done", {31'd0, bus.done}, 32'd0);
            checkOutput("lateRvalid_RUWr", {31'd0, bus.RUWr}, 32'd0);
            checkOutput("lateRvalid_ready", {31'd0, bus.req_ready}, 32'd1);
            @(negedge clk);
        end

        applyStimulus(vecs[1]);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got 0 expected 1");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
